// File: rtl/unified_buffer_stream_if.sv
// Host-facing word stream: valid/ready handshake with an end-of-tile marker.
interface unified_buffer_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/unified_buffer_stream.sv
// Operand/result memory with wrap-around tile load/store and a valid/ready
// stream of one tile to the host. Reads always see the pre-write contents.
module unified_buffer_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TILE   = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    host_wr_en,
    input  logic [ADDR_W-1:0]       host_wr_addr,
    input  logic [DATA_W-1:0]       host_wr_data,
    input  logic [ADDR_W-1:0]       tile_addr,
    input  logic                    load_req,
    output logic [TILE*DATA_W-1:0]  tile_out,
    output logic                    tile_out_valid,
    input  logic                    store_req,
    input  logic                    acc_valid,
    input  logic [TILE*DATA_W-1:0]  acc_data,
    output logic                    store_done,
    input  logic                    ext_req,
    output logic                    busy,
    unified_buffer_stream_if.master out_if
);
    localparam int REM_W = $clog2(TILE + 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [DATA_W-1:0]      mem_d [DEPTH];
    logic [ADDR_W-1:0]      addr_k [TILE];
    logic [TILE*DATA_W-1:0] tile_q, tile_d;
    logic                   tile_valid_q, store_done_q;
    logic                   store_fire;

    logic [0:0]             state_q, state_d;
    logic [ADDR_W-1:0]      ptr_q, ptr_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [DATA_W-1:0]      data_q, data_d;

    assign store_fire = store_req & acc_valid;

    // Power-of-two depth: truncation to ADDR_W bits gives the wrap-around.
    always_comb begin
        for (int k = 0; k < TILE; k++) begin
            addr_k[k] = tile_addr + ADDR_W'(k);
        end
    end

    // Store is applied after the host write so it wins on a shared address.
    always_comb begin
        mem_d = mem_q;
        if (host_wr_en) begin
            mem_d[host_wr_addr] = host_wr_data;
        end
        if (store_fire) begin
            for (int k = 0; k < TILE; k++) begin
                mem_d[addr_k[k]] = acc_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        tile_d = '0;
        for (int k = 0; k < TILE; k++) begin
            tile_d[k*DATA_W +: DATA_W] = mem_q[addr_k[k]];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (ext_req) begin
                    state_d = STREAM;
                    ptr_d   = tile_addr + ADDR_W'(1);
                    rem_d   = REM_W'(TILE);
                    data_d  = mem_q[tile_addr];
                end
            end
            default: begin
                if (out_if.out_ready) begin
                    if (rem_q > REM_W'(1)) begin
                        data_d = mem_q[ptr_q];
                        ptr_d  = ptr_q + ADDR_W'(1);
                        rem_d  = rem_q - REM_W'(1);
                    end else begin
                        state_d = IDLE;
                        rem_d   = '0;
                        data_d  = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tile_q       <= '0;
            tile_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            state_q      <= IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            data_q       <= '0;
        end else begin
            mem_q        <= mem_d;
            tile_valid_q <= load_req;
            store_done_q <= store_fire;
            if (load_req) begin
                tile_q <= tile_d;
            end
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    assign tile_out         = tile_q;
    assign tile_out_valid   = tile_valid_q;
    assign store_done       = store_done_q;
    assign busy             = (state_q == STREAM);
    assign out_if.out_valid = (state_q == STREAM);
    assign out_if.out_last  = (state_q == STREAM) && (rem_q == REM_W'(1));
    assign out_if.out_data  = data_q;
endmodule
